// File: rtl/game_link_uart.sv
// Two-board game link: frames local START/SCORE events onto an 8N1 UART and
// parses START/SCORE frames arriving from the opponent board.
module game_link_uart #(
    parameter int         CLKS_PER_BIT = 651,
    parameter logic [7:0] HDR_START    = 8'hA5,
    parameter logic [7:0] HDR_SCORE    = 8'hC5
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       send_start,
    input  logic       send_score,
    input  logic [6:0] my_score,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       uart_start,
    output logic [6:0] op_score,
    output logic       op_score_valid,
    output logic       rx_frame_err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
    typedef enum logic       {P_WAIT_HDR, P_WAIT_PAY} parse_state_e;

    // ---------------- transmit side ----------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic             tx_second_q, tx_second_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       tx_pay_q, tx_pay_d;
    logic             uart_tx_q, uart_tx_d;
    logic             start_pend_q, start_pend_d;
    logic             score_pend_q, score_pend_d;
    logic [6:0]       score_q, score_d;
    logic             launch;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_second_d = tx_second_q;
        tx_shift_d  = tx_shift_q;
        tx_pay_d    = tx_pay_q;
        uart_tx_d   = uart_tx_q;
        launch      = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                uart_tx_d = 1'b1;
                launch    = start_pend_q | score_pend_q;
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                    uart_tx_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        uart_tx_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        uart_tx_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!tx_second_q) begin
                        tx_second_d = 1'b1;
                        tx_shift_d  = tx_pay_q;
                        tx_state_d  = TX_START;
                        uart_tx_d   = 1'b0;
                    end else if (start_pend_q | score_pend_q) begin
                        // Chain the next pending frame with no idle gap on the line.
                        launch = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        uart_tx_d  = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // START wins when both are pending; the score frame is taken from the latched value.
        if (launch) begin
            tx_state_d  = TX_START;
            tx_cnt_d    = '0;
            tx_second_d = 1'b0;
            tx_shift_d  = start_pend_q ? HDR_START : HDR_SCORE;
            tx_pay_d    = start_pend_q ? 8'h00 : {1'b0, score_q};
            uart_tx_d   = 1'b0;
        end

        // A pulse arriving in the launch cycle re-arms the flag after it is consumed.
        start_pend_d = send_start | (start_pend_q & ~launch);
        score_pend_d = send_score | (score_pend_q & ~(launch & ~start_pend_q));
        score_d      = send_score ? my_score : score_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= 3'd0;
            tx_second_q  <= 1'b0;
            tx_shift_q   <= 8'h00;
            tx_pay_q     <= 8'h00;
            uart_tx_q    <= 1'b1;
            start_pend_q <= 1'b0;
            score_pend_q <= 1'b0;
            score_q      <= 7'd0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_second_q  <= tx_second_d;
            tx_shift_q   <= tx_shift_d;
            tx_pay_q     <= tx_pay_d;
            uart_tx_q    <= uart_tx_d;
            start_pend_q <= start_pend_d;
            score_pend_q <= score_pend_d;
            score_q      <= score_d;
        end
    end

    // ---------------- receive side ----------------
    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_err_q, rx_err_d;
    logic             rx_done, rx_bad;

    parse_state_e     ps_q, ps_d;
    logic             hdr_score_q, hdr_score_d;
    logic [6:0]       op_score_q, op_score_d;
    logic             op_valid_q, op_valid_d;
    logic             uart_start_q, uart_start_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_err_d   = rx_err_q;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bad     = 1'b1;
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        ps_d         = ps_q;
        hdr_score_d  = hdr_score_q;
        op_score_d   = op_score_q;
        op_valid_d   = op_valid_q;
        uart_start_d = 1'b0;

        if (rx_done) begin
            // Any byte with bit7 set is a header candidate, even mid-frame (resync).
            if (ps_q == P_WAIT_HDR || rx_shift_q[7]) begin
                if (rx_shift_q == HDR_START) begin
                    ps_d        = P_WAIT_PAY;
                    hdr_score_d = 1'b0;
                end else if (rx_shift_q == HDR_SCORE) begin
                    ps_d        = P_WAIT_PAY;
                    hdr_score_d = 1'b1;
                end else begin
                    ps_d = P_WAIT_HDR;
                end
            end else begin
                ps_d = P_WAIT_HDR;
                if (hdr_score_q) begin
                    op_score_d = rx_shift_q[6:0];
                    op_valid_d = 1'b1;
                end else if (rx_shift_q == 8'h00) begin
                    uart_start_d = 1'b1;
                    op_valid_d   = 1'b0;
                end
            end
        end else if (rx_bad) begin
            ps_d = P_WAIT_HDR;
        end

        if (send_start) op_valid_d = 1'b0;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_err_q     <= 1'b0;
            ps_q         <= P_WAIT_HDR;
            hdr_score_q  <= 1'b0;
            op_score_q   <= 7'd0;
            op_valid_q   <= 1'b0;
            uart_start_q <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_err_q     <= rx_err_d;
            ps_q         <= ps_d;
            hdr_score_q  <= hdr_score_d;
            op_score_q   <= op_score_d;
            op_valid_q   <= op_valid_d;
            uart_start_q <= uart_start_d;
        end
    end

    assign uart_tx        = uart_tx_q;
    assign tx_busy        = start_pend_q | score_pend_q | (tx_state_q != TX_IDLE);
    assign uart_start     = uart_start_q;
    assign op_score       = op_score_q;
    assign op_score_valid = op_valid_q;
    assign rx_frame_err   = rx_err_q;

endmodule

// File: tb/tb_game_link_uart.sv
// Self-checking bench for game_link_uart: line-level TX decoder plus a byte-level
// model of the frame parser, driven with directed and randomized traffic.
module tb_game_link_uart;

    localparam int         CPB       = 64;
    localparam logic [7:0] HDR_START = 8'hA5;
    localparam logic [7:0] HDR_SCORE = 8'hC5;

    logic       pclk = 1'b0;
    logic       rst;
    logic       send_start;
    logic       send_score;
    logic [6:0] my_score;
    logic       uart_rx;
    logic       uart_tx;
    logic       tx_busy;
    logic       uart_start;
    logic [6:0] op_score;
    logic       op_score_valid;
    logic       rx_frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    game_link_uart #(
        .CLKS_PER_BIT(CPB),
        .HDR_START   (HDR_START),
        .HDR_SCORE   (HDR_SCORE)
    ) dut (
        .pclk          (pclk),
        .rst           (rst),
        .send_start    (send_start),
        .send_score    (send_score),
        .my_score      (my_score),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .uart_start    (uart_start),
        .op_score      (op_score),
        .op_score_valid(op_score_valid),
        .rx_frame_err  (rx_frame_err)
    );

    // uart_start observation: high cycles and rising edges
    int   start_hi     = 0;
    int   start_pulses = 0;
    logic start_prev   = 1'b0;
    always @(negedge pclk) begin
        if (uart_start === 1'b1) start_hi <= start_hi + 1;
        if (uart_start === 1'b1 && start_prev !== 1'b1) start_pulses <= start_pulses + 1;
        start_prev <= uart_start;
    end

    // Decoder for the transmitted line: records each byte, its start cycle and stop level
    logic [7:0] tx_bytes[$];
    int         tx_times[$];
    logic       tx_stops[$];
    logic       mon_en = 1'b1;
    initial begin : tx_monitor
        logic [7:0] b;
        int         t;
        forever begin
            @(negedge pclk);
            if (mon_en && uart_tx === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) @(negedge pclk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge pclk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge pclk);
                tx_bytes.push_back(b);
                tx_times.push_back(t);
                tx_stops.push_back(uart_tx);
            end
        end
    end

    // Receive-side reference: what the opponent link should report after each byte
    int         m_hdr    = 0;   // 0 none, 1 START header seen, 2 SCORE header seen
    logic [6:0] m_score  = 7'd0;
    logic       m_valid  = 1'b0;
    logic       m_err    = 1'b0;
    int         m_starts = 0;

    task automatic model_byte(input logic [7:0] b, input logic ok);
        if (!ok) begin
            m_err = 1'b1;
            m_hdr = 0;
        end else if (m_hdr == 0 || b[7]) begin
            m_hdr = (b == HDR_START) ? 1 : (b == HDR_SCORE) ? 2 : 0;
        end else begin
            if (m_hdr == 2) begin
                m_score = b[6:0];
                m_valid = 1'b1;
            end else if (b == 8'h00) begin
                m_starts++;
                m_valid = 1'b0;
            end
            m_hdr = 0;
        end
    endtask

    // Serialise one byte on uart_rx; ok=0 sends a low stop bit followed by an idle gap
    task automatic rx_byte(input logic [7:0] b, input logic ok);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge pclk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge pclk);
        end
        uart_rx = ok;
        repeat (CPB) @(negedge pclk);
        if (!ok) begin
            uart_rx = 1'b1;
            repeat (CPB) @(negedge pclk);
        end
        model_byte(b, ok);
    endtask

    task automatic pulse_send(input logic do_start, input logic do_score, input logic [6:0] sc);
        send_start = do_start;
        send_score = do_score;
        my_score   = sc;
        @(negedge pclk);
        send_start = 1'b0;
        send_score = 1'b0;
        if (do_start) m_valid = 1'b0;
    endtask

    task automatic wait_tx_idle(output int fall);
        int n;
        fall = -1;
        n    = 0;
        while (fall < 0 && n < 80 * CPB) begin
            if (tx_busy === 1'b0) fall = cyc;
            else begin
                @(negedge pclk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        send_start = 1'b0;
        send_score = 1'b0;
        my_score   = 7'd0;
        uart_rx    = 1'b1;
        repeat (3) @(negedge pclk);
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        checks++; if (uart_start !== 1'b0) begin failures++; $display("FAIL reset_uart_start: got %b expected 0", uart_start); end
        checks++; if (op_score !== 7'd0) begin failures++; $display("FAIL reset_op_score: got %0d expected 0", op_score); end
        checks++; if (op_score_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid: got %b expected 0", op_score_valid); end
        checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
        rst = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_start_frame();
        int         k, t0, fall;
        logic [7:0] exp[$];
        tx_bytes.delete(); tx_times.delete(); tx_stops.delete();
        exp = '{HDR_START, 8'h00};
        k   = cyc;
        pulse_send(1'b1, 1'b0, 7'd0);
        checks++; if (tx_busy !== 1'b1 || uart_tx !== 1'b1) begin failures++; $display("FAIL t1_after_edge1: busy=%b tx=%b expected busy=1 tx=1", tx_busy, uart_tx); end
        @(negedge pclk);
        checks++; if (uart_tx !== 1'b0) begin failures++; $display("FAIL t1_tx_low_edge2: got %b expected 0", uart_tx); end
        t0 = k + 2;
        wait_tx_idle(fall);
        checks++; if (fall != t0 + 20 * CPB) begin failures++; $display("FAIL t1_busy_fall: got cycle %0d expected %0d", fall, t0 + 20 * CPB); end
        checks++; if (tx_bytes.size() != exp.size()) begin failures++; $display("FAIL t1_byte_count: got %0d expected %0d", tx_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= tx_bytes.size()) begin
                failures++; $display("FAIL t1_byte%0d: missing, expected %02h", i, exp[i]);
            end else if (tx_bytes[i] !== exp[i] || tx_times[i] != t0 + i * 10 * CPB || tx_stops[i] !== 1'b1) begin
                failures++; $display("FAIL t1_byte%0d: got %02h at %0d stop %b, expected %02h at %0d stop 1",
                                     i, tx_bytes[i], tx_times[i], tx_stops[i], exp[i], t0 + i * 10 * CPB);
            end
        end
    endtask

    task automatic test_score_then_start();
        int         k, t0, fall;
        logic [6:0] s;
        logic [7:0] exp[$];
        tx_bytes.delete(); tx_times.delete(); tx_stops.delete();
        s   = 7'($urandom_range(0, 127));
        exp = '{HDR_SCORE, {1'b0, s}, HDR_START, 8'h00};
        k   = cyc;
        pulse_send(1'b0, 1'b1, s);
        repeat (99) @(negedge pclk);
        pulse_send(1'b1, 1'b0, 7'($urandom_range(0, 127)));
        t0 = k + 2;
        wait_tx_idle(fall);
        checks++; if (fall != t0 + 40 * CPB) begin failures++; $display("FAIL t2_busy_fall: got cycle %0d expected %0d", fall, t0 + 40 * CPB); end
        checks++; if (tx_bytes.size() != exp.size()) begin failures++; $display("FAIL t2_byte_count: got %0d expected %0d", tx_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= tx_bytes.size()) begin
                failures++; $display("FAIL t2_byte%0d: missing, expected %02h", i, exp[i]);
            end else if (tx_bytes[i] !== exp[i] || tx_times[i] != t0 + i * 10 * CPB || tx_stops[i] !== 1'b1) begin
                failures++; $display("FAIL t2_byte%0d: got %02h at %0d stop %b, expected %02h at %0d stop 1",
                                     i, tx_bytes[i], tx_times[i], tx_stops[i], exp[i], t0 + i * 10 * CPB);
            end
        end
    endtask

    // Requests made while a frame shifts: repeats merge, START goes first, latest score wins
    task automatic test_merge_priority();
        int         k, t0, fall;
        logic [6:0] s1, s2;
        logic [7:0] exp[$];
        tx_bytes.delete(); tx_times.delete(); tx_stops.delete();
        s1  = 7'($urandom_range(0, 127));
        s2  = 7'($urandom_range(0, 127));
        exp = '{HDR_START, 8'h00, HDR_START, 8'h00, HDR_SCORE, {1'b0, s2}};
        k   = cyc;
        pulse_send(1'b1, 1'b0, 7'd0);
        repeat (199) @(negedge pclk);
        pulse_send(1'b0, 1'b1, s1);
        pulse_send(1'b1, 1'b0, 7'd0);
        pulse_send(1'b0, 1'b1, s2);
        pulse_send(1'b1, 1'b0, 7'd0);
        t0 = k + 2;
        wait_tx_idle(fall);
        checks++; if (fall != t0 + 60 * CPB) begin failures++; $display("FAIL merge_busy_fall: got cycle %0d expected %0d", fall, t0 + 60 * CPB); end
        checks++; if (tx_bytes.size() != exp.size()) begin failures++; $display("FAIL merge_byte_count: got %0d expected %0d", tx_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= tx_bytes.size()) begin
                failures++; $display("FAIL merge_byte%0d: missing, expected %02h", i, exp[i]);
            end else if (tx_bytes[i] !== exp[i] || tx_times[i] != t0 + i * 10 * CPB || tx_stops[i] !== 1'b1) begin
                failures++; $display("FAIL merge_byte%0d: got %02h at %0d stop %b, expected %02h at %0d stop 1",
                                     i, tx_bytes[i], tx_times[i], tx_stops[i], exp[i], t0 + i * 10 * CPB);
            end
        end
    endtask

    // Score frame, start frame, truncated score (resync), framing error, start frame
    task automatic test_rx_directed();
        logic [7:0] db[10];
        logic       dok[10];
        db  = '{8'hC5, 8'h17, 8'hA5, 8'h00, 8'hC5, 8'hA5, 8'h00, 8'h5A, 8'hA5, 8'h00};
        dok = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            rx_byte(db[i], dok[i]);
            checks++; if (op_score !== m_score) begin failures++; $display("FAIL rx_dir%0d_op_score: got %0d expected %0d", i, op_score, m_score); end
            checks++; if (op_score_valid !== m_valid) begin failures++; $display("FAIL rx_dir%0d_valid: got %b expected %b", i, op_score_valid, m_valid); end
            checks++; if (rx_frame_err !== m_err) begin failures++; $display("FAIL rx_dir%0d_frame_err: got %b expected %b", i, rx_frame_err, m_err); end
            checks++; if (start_pulses != m_starts) begin failures++; $display("FAIL rx_dir%0d_starts: got %0d expected %0d", i, start_pulses, m_starts); end
        end
        checks++; if (op_score !== 7'd23) begin failures++; $display("FAIL rx_dir_final_score: got %0d expected 23", op_score); end
        checks++; if (start_hi != start_pulses) begin failures++; $display("FAIL rx_dir_pulse_width: high cycles %0d expected %0d", start_hi, start_pulses); end
    endtask

    task automatic test_rx_random();
        logic [7:0] b;
        logic       ok;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0:       b = HDR_START;
                1:       b = HDR_SCORE;
                2:       b = 8'h00;
                3:       b = 8'($urandom_range(0, 127));
                default: b = 8'($urandom_range(0, 255));
            endcase
            ok = ($urandom_range(0, 7) != 0);
            rx_byte(b, ok);
            checks++; if (op_score !== m_score) begin failures++; $display("FAIL rx_rand%0d_op_score: got %0d expected %0d", i, op_score, m_score); end
            checks++; if (op_score_valid !== m_valid) begin failures++; $display("FAIL rx_rand%0d_valid: got %b expected %b", i, op_score_valid, m_valid); end
            checks++; if (rx_frame_err !== m_err) begin failures++; $display("FAIL rx_rand%0d_frame_err: got %b expected %b", i, rx_frame_err, m_err); end
            checks++; if (start_pulses != m_starts) begin failures++; $display("FAIL rx_rand%0d_starts: got %0d expected %0d", i, start_pulses, m_starts); end
        end
        checks++; if (start_hi != start_pulses) begin failures++; $display("FAIL rx_rand_pulse_width: high cycles %0d expected %0d", start_hi, start_pulses); end
    endtask

    // A local START begins a new game and invalidates the stored opponent score
    task automatic test_new_game_clear();
        logic [6:0] s;
        int         fall;
        s = 7'($urandom_range(0, 127));
        rx_byte(HDR_SCORE, 1'b1);
        rx_byte({1'b0, s}, 1'b1);
        checks++; if (op_score_valid !== 1'b1 || op_score !== s) begin failures++; $display("FAIL newgame_rx: valid=%b score=%0d expected valid=1 score=%0d", op_score_valid, op_score, s); end
        pulse_send(1'b1, 1'b0, 7'd0);
        checks++; if (op_score_valid !== 1'b0) begin failures++; $display("FAIL newgame_valid_clear: got %b expected 0", op_score_valid); end
        checks++; if (op_score !== s) begin failures++; $display("FAIL newgame_score_kept: got %0d expected %0d", op_score, s); end
        wait_tx_idle(fall);
        checks++; if (fall < 0) begin failures++; $display("FAIL newgame_tx_timeout: tx_busy still %b", tx_busy); end
    endtask

    task automatic test_reset_mid_tx();
        logic [6:0] s;
        mon_en = 1'b0;
        pulse_send(1'b1, 1'b0, 7'd0);
        repeat (15 * CPB) @(negedge pclk);
        checks++; if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin failures++; $display("FAIL rstmid_before: tx=%b busy=%b expected tx=0 busy=1", uart_tx, tx_busy); end
        rst = 1'b1;
        #1;
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL rstmid_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_tx_busy: got %b expected 0", tx_busy); end
        checks++; if (rx_frame_err !== 1'b0 || op_score !== 7'd0 || op_score_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_rx_state: err=%b score=%0d valid=%b expected 0/0/0", rx_frame_err, op_score, op_score_valid);
        end
        repeat (3) @(negedge pclk);
        rst     = 1'b0;
        m_hdr   = 0;
        m_score = 7'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        repeat (2) @(negedge pclk);

        // Header, then a short low glitch, then the payload: a phantom byte would break the frame
        s = 7'($urandom_range(1, 127));
        rx_byte(HDR_SCORE, 1'b1);
        uart_rx = 1'b0;
        repeat (CPB / 2 - 8) @(negedge pclk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge pclk);
        checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL glitch_frame_err: got %b expected 0", rx_frame_err); end
        checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_tx_quiet: tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy); end
        rx_byte({1'b0, s}, 1'b1);
        checks++; if (op_score !== s || op_score_valid !== 1'b1) begin
            failures++; $display("FAIL glitch_payload: score=%0d valid=%b expected score=%0d valid=1", op_score, op_score_valid, s);
        end
    endtask

    initial begin
        test_reset();
        test_start_frame();
        test_score_then_start();
        test_merge_priority();
        test_rx_directed();
        test_rx_random();
        test_new_game_clear();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
